softmax_stream_arbiter: RTL



---
 rtl/softmax_stream_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/softmax_stream_arbiter.sv
// rtl/softmax_stream_arbiter.sv - round-robin matrix-granular arbiter sharing one softmax pipeline between REQ streams
module softmax_stream_arbiter #(
    parameter int D_W          = 8,
    parameter int D_W_ACC      = 32,
    parameter int REQ          = 4,
    parameter int N            = 32,
    parameter int MATRIXSIZE_W = 16,
    parameter int OUTSTANDING  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REQ*D_W_ACC-1:0]   s_tdata,
    input  logic [REQ-1:0]           s_tvalid,
    input  logic [REQ-1:0]           s_tlast,
    output logic [REQ-1:0]           s_tready,
    output logic [D_W_ACC-1:0]       sm_in_tdata,
    output logic                     sm_in_tvalid,
    output logic                     sm_in_tlast,
    input  logic                     sm_in_tready,
    input  logic [D_W-1:0]           sm_out_tdata,
    input  logic                     sm_out_tvalid,
    input  logic                     sm_out_tlast,
    output logic                     sm_out_tready,
    output logic [REQ*D_W-1:0]       m_tdata,
    output logic [REQ-1:0]           m_tvalid,
    output logic [REQ-1:0]           m_tlast,
    input  logic [REQ-1:0]           m_tready,
    output logic [$clog2(REQ)-1:0]   grant_id,
    output logic                     busy,
    output logic                     len_err
);

    localparam int ID_W  = $clog2(REQ);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [MATRIXSIZE_W-1:0] LAST_BEAT = MATRIXSIZE_W'(N * N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         grant_id_q, rr_ptr_q;
    logic [MATRIXSIZE_W-1:0] in_cnt_q;
    logic [ID_W-1:0]         fifo_q [OUTSTANDING];
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    len_err_q, len_err_d;

    logic                    fifo_empty, fifo_full, push, pop, in_hs, last_beat, any_valid;
    logic [ID_W-1:0]         pick, cand, head;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING));
    assign head       = fifo_q[rd_ptr_q];
    assign last_beat  = (in_cnt_q == LAST_BEAT);
    assign in_hs      = (state_q == STREAM) && sm_in_tvalid && sm_in_tready;
    assign pop        = !fifo_empty && sm_out_tvalid && sm_out_tready && sm_out_tlast;
    // A pop in the same cycle frees a slot, so a full FIFO may still accept a grant.
    assign push       = (state_q == IDLE) && any_valid && (!fifo_full || pop);
    assign grant_id   = grant_id_q;
    assign busy       = (state_q == STREAM) || !fifo_empty;
    assign len_err    = len_err_q;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        cand      = '0;
        for (int i = 0; i < REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % REQ);
            if (!any_valid && s_tvalid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    // Next state: IDLE grants a whole matrix, STREAM releases on the final counted beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push) state_d = STREAM;
            STREAM:  if (in_hs && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Input path: connect only the granted lane while streaming.
    always_comb begin
        sm_in_tdata  = '0;
        sm_in_tvalid = 1'b0;
        sm_in_tlast  = 1'b0;
        s_tready     = '0;
        if (state_q == STREAM) begin
            sm_in_tdata          = s_tdata[grant_id_q*D_W_ACC +: D_W_ACC];
            sm_in_tvalid         = s_tvalid[grant_id_q];
            sm_in_tlast          = last_beat;
            s_tready[grant_id_q] = sm_in_tready;
        end
    end

    // Output path: route softmax results to the owner of the oldest in-flight matrix.
    always_comb begin
        m_tdata       = '0;
        m_tvalid      = '0;
        m_tlast       = '0;
        sm_out_tready = 1'b0;
        if (!fifo_empty) begin
            m_tdata[head*D_W +: D_W] = sm_out_tdata;
            m_tvalid[head]           = sm_out_tvalid;
            m_tlast[head]            = sm_out_tlast;
            sm_out_tready            = m_tready[head];
        end
    end

    // Sticky error: tlast disagreeing with the beat count, or output with nothing in flight.
    always_comb begin
        len_err_d = len_err_q;
        if (in_hs && (s_tlast[grant_id_q] != last_beat)) len_err_d = 1'b1;
        if (fifo_empty && sm_out_tvalid) len_err_d = 1'b1;
    end

    // Control state, counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            in_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_err_q <= len_err_d;
            if (push) begin
                grant_id_q <= pick;
                wr_ptr_q   <= (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
            if (in_hs) begin
                if (last_beat) begin
                    in_cnt_q <= '0;
                    rr_ptr_q <= (grant_id_q == ID_W'(REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
                end else begin
                    in_cnt_q <= in_cnt_q + MATRIXSIZE_W'(1);
                end
            end
        end
    end

    // ID FIFO storage; contents are only meaningful below cnt_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && push) fifo_q[wr_ptr_q] <= pick;
    end

endmodule
